// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that funnels NREQ register-file write
// requesters onto a single write port, with one cycle of output latency.
// Optional zero-fill sequencer (clear_start / clear_busy) is compiled in only
// when RFARB_CLEAR_EN is defined; without it clear_start is ignored and
// clear_busy is tied low.
module rf_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int REGNUM = 32,
  parameter int WIDTH  = 64,
  localparam int AW    = $clog2(REGNUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  rf_enable,
  output logic                  rf_wr,
  output logic [AW-1:0]         rf_add_wr,
  output logic [WIDTH-1:0]      rf_datain
);

  localparam int PW = $clog2(NREQ);

  // Per-lane views of the flat request buses.
  logic [NREQ-1:0][AW-1:0]    addr_a;
  logic [NREQ-1:0][WIDTH-1:0] data_a;
  assign addr_a = req_addr;
  assign data_a = req_data;

  logic [PW-1:0]    rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    gidx;
  logic [AW-1:0]    gaddr;
  logic [WIDTH-1:0] gdata;
  logic             in_idle;
  logic             clr_go;
  logic             clr_wr;
  logic [AW-1:0]    clr_addr;
  logic             xfer;

  // Rotating-priority search: walk from the farthest offset back to rr_ptr so
  // the closest valid requester (upward from rr_ptr) is the one left standing.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant = '0;
    gidx  = '0;
    gaddr = '0;
    gdata = '0;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = idx;
        gaddr      = addr_a[idx];
        gdata      = data_a[idx];
      end
    end
  end

  // Grants only while arbitrating; a clear request wins the cycle it arrives.
  assign req_ready = (~reset & in_idle & ~clr_go) ? grant : '0;
  assign xfer      = |req_ready;

`ifdef RFARB_CLEAR_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // FSM state and zero-fill address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: clear_start only counts in IDLE, so a pulse mid-sequence is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_idle = 1'b0;
    clr_go  = 1'b0;
    clr_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        in_idle = 1'b1;
        if (clear_start) begin
          clr_go  = 1'b1;
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        if (cnt_q == AW'(REGNUM-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_addr   = cnt_q;
  assign clear_busy = (state_q == CLEAR) & ~reset;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign in_idle    = 1'b1;
  assign clr_go     = 1'b0;
  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clear_busy = 1'b0;
`endif

  // Registered write port and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rf_enable <= 1'b0;
      rf_wr     <= 1'b0;
      rf_add_wr <= '0;
      rf_datain <= '0;
    end else begin
      rf_enable <= 1'b1;
      rf_wr     <= xfer | clr_wr;
      if (xfer) begin
        rf_add_wr <= gaddr;
        rf_datain <= gdata;
        rr_ptr    <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
      end else if (clr_wr) begin
        rf_add_wr <= clr_addr;
        rf_datain <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a random
// run checked against a behavioural model (pointer + pending clear countdown).
// Clear-path scenarios follow RFARB_CLEAR_EN.
module tb_rf_write_arbiter;
  localparam int NREQ   = 4;
  localparam int REGNUM = 32;
  localparam int WIDTH  = 64;
  localparam int AW     = $clog2(REGNUM);
`ifdef RFARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  clear_start = 1'b0;
  logic                  clear_busy, rf_enable, rf_wr;
  logic [AW-1:0]         rf_add_wr;
  logic [WIDTH-1:0]      rf_datain;

  rf_write_arbiter #(.NREQ(NREQ), .REGNUM(REGNUM), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
    .clear_busy(clear_busy), .rf_enable(rf_enable), .rf_wr(rf_wr),
    .rf_add_wr(rf_add_wr), .rf_datain(rf_datain));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_ptr = 0;
  bit               m_clear = 0;
  int               m_cnt = 0;
  logic             e_wr = 0, e_en = 0;
  logic [AW-1:0]    e_addr = '0;
  logic [WIDTH-1:0] e_data = '0;

  function automatic int m_pick();
    if (reset || m_clear || (CLR_EN && clear_start)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (((req_valid >> i) & NREQ'(1)) != '0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int g;
    g = m_pick();
    return (g < 0) ? '0 : (NREQ'(1) << g);
  endfunction

  function automatic logic [NREQ*AW-1:0] rnd_addr();
    return (NREQ*AW)'($urandom);
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rnd_data();
    logic [NREQ*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ*WIDTH/32; i++) r = (r << 32) | (NREQ*WIDTH)'($urandom);
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [NREQ-1:0] v, input logic cs,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*WIDTH-1:0] d);
    @(negedge clk);
    reset = rst; req_valid = v; clear_start = cs; req_addr = a; req_data = d;
    #1;
  endtask

  // Advance the model with the inputs currently applied, then take the edge.
  task automatic tick();
    int g;
    g = m_pick();
    if (reset) begin
      m_ptr = 0; m_clear = 0; m_cnt = 0;
      e_en = 0; e_wr = 0; e_addr = '0; e_data = '0;
    end else begin
      e_en = 1; e_wr = 0;
      if (g >= 0) begin
        e_wr = 1;
        e_addr = AW'(req_addr >> (g*AW));
        e_data = WIDTH'(req_data >> (g*WIDTH));
        m_ptr = (g + 1) % NREQ;
      end else if (m_clear) begin
        e_wr = 1; e_addr = AW'(m_cnt); e_data = '0;
        m_cnt++;
        if (m_cnt == REGNUM) begin m_clear = 0; m_cnt = 0; end
      end else if (CLR_EN && clear_start) begin
        m_clear = 1; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b1111, 1'b0, rnd_addr(), rnd_data());
      checks++;
      if (req_ready !== 4'b0000 || clear_busy !== 1'b0) begin
        errors++; $display("FAIL reset_ready: ready=%b busy=%b want 0000/0", req_ready, clear_busy);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b0 || rf_enable !== 1'b0 || rf_add_wr !== '0 || rf_datain !== '0) begin
        errors++; $display("FAIL reset_out: wr=%b en=%b addr=%0d data=%h want all 0", rf_wr, rf_enable, rf_add_wr, rf_datain);
      end
    end
    drive(1'b0, 4'b0000, 1'b0, rnd_addr(), rnd_data());
    tick();
    checks++;
    if (rf_enable !== 1'b1 || rf_wr !== 1'b0) begin
      errors++; $display("FAIL reset_release: en=%b wr=%b want 1/0", rf_enable, rf_wr);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       expg;
    for (int n = 0; n < 5; n++) begin
      a = rnd_addr(); d = rnd_data();
      drive(1'b0, 4'b1111, 1'b0, a, d);
      expg = '0; expg[n % NREQ] = 1'b1;
      checks++;
      if (req_ready !== expg) begin
        errors++; $display("FAIL rr_grant[%0d]: ready=%b want %b", n, req_ready, expg);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b1 || rf_add_wr !== AW'(a >> ((n % NREQ)*AW)) ||
          rf_datain !== WIDTH'(d >> ((n % NREQ)*WIDTH))) begin
        errors++; $display("FAIL rr_write[%0d]: wr=%b addr=%0d data=%h", n, rf_wr, rf_add_wr, rf_datain);
      end
    end
  endtask

  task automatic test_latency();
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    a = rnd_addr(); d = rnd_data();
    a[2*AW +: AW] = 5'd5;
    d[2*WIDTH +: WIDTH] = 64'hA5;
    drive(1'b0, 4'b0100, 1'b0, a, d);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL lat_grant: ready=%b want 0100", req_ready);
    end
    tick();
    checks++;
    if (rf_wr !== 1'b1 || rf_add_wr !== 5'd5 || rf_datain !== 64'hA5) begin
      errors++; $display("FAIL lat_write: wr=%b addr=%0d data=%h want 1/5/a5", rf_wr, rf_add_wr, rf_datain);
    end
    drive(1'b0, 4'b0000, 1'b0, rnd_addr(), rnd_data());
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL lat_idle_ready: ready=%b want 0000", req_ready);
    end
    tick();
    checks++;
    if (rf_wr !== 1'b0 || rf_add_wr !== 5'd5 || rf_datain !== 64'hA5) begin
      errors++; $display("FAIL lat_hold: wr=%b addr=%0d data=%h want 0/5/a5", rf_wr, rf_add_wr, rf_datain);
    end
  endtask

  task automatic test_same_addr();
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    drive(1'b1, 4'b0000, 1'b0, '0, '0);
    tick();
    a = rnd_addr(); d = rnd_data();
    a[0 +: AW] = 5'd7; a[AW +: AW] = 5'd7;
    d[0 +: WIDTH] = 64'h11; d[WIDTH +: WIDTH] = 64'h22;
    drive(1'b0, 4'b0011, 1'b0, a, d);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL same_grant0: ready=%b want 0001", req_ready);
    end
    tick();
    checks++;
    if (rf_wr !== 1'b1 || rf_add_wr !== 5'd7 || rf_datain !== 64'h11) begin
      errors++; $display("FAIL same_write0: wr=%b addr=%0d data=%h want 1/7/11", rf_wr, rf_add_wr, rf_datain);
    end
    drive(1'b0, 4'b0010, 1'b0, a, d);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL same_grant1: ready=%b want 0010", req_ready);
    end
    tick();
    checks++;
    if (rf_wr !== 1'b1 || rf_add_wr !== 5'd7 || rf_datain !== 64'h22) begin
      errors++; $display("FAIL same_write1: wr=%b addr=%0d data=%h want 1/7/22", rf_wr, rf_add_wr, rf_datain);
    end
  endtask

`ifdef RFARB_CLEAR_EN
  task automatic test_clear();
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    a = rnd_addr(); d = rnd_data();
    drive(1'b0, 4'b0001, 1'b1, a, d);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL clr_start_ready: ready=%b want 0000", req_ready);
    end
    tick();
    for (int k = 0; k < REGNUM; k++) begin
      drive(1'b0, 4'b0001, (k == 10), a, d);
      checks++;
      if (req_ready !== 4'b0000 || clear_busy !== 1'b1) begin
        errors++; $display("FAIL clr_busy[%0d]: ready=%b busy=%b want 0000/1", k, req_ready, clear_busy);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b1 || rf_add_wr !== AW'(k) || rf_datain !== '0) begin
        errors++; $display("FAIL clr_write[%0d]: wr=%b addr=%0d data=%h", k, rf_wr, rf_add_wr, rf_datain);
      end
    end
    drive(1'b0, 4'b0001, 1'b0, a, d);
    checks++;
    if (clear_busy !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL clr_exit: busy=%b ready=%b want 0/0001", clear_busy, req_ready);
    end
    tick();
    checks++;
    if (rf_wr !== 1'b1 || rf_add_wr !== a[0 +: AW] || rf_datain !== d[0 +: WIDTH]) begin
      errors++; $display("FAIL clr_pending: wr=%b addr=%0d data=%h", rf_wr, rf_add_wr, rf_datain);
    end
  endtask

  task automatic test_reset_mid_clear();
    drive(1'b0, 4'b0000, 1'b1, rnd_addr(), rnd_data());
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b0000, 1'b0, rnd_addr(), rnd_data());
      tick();
    end
    drive(1'b1, 4'b0000, 1'b0, rnd_addr(), rnd_data());
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rf_wr !== 1'b0 || clear_busy !== 1'b0) begin
        errors++; $display("FAIL midclr[%0d]: wr=%b busy=%b want 0/0", c, rf_wr, clear_busy);
      end
      drive(1'b0, 4'b0000, 1'b0, rnd_addr(), rnd_data());
      tick();
    end
  endtask
`else
  task automatic test_clear_disabled();
    drive(1'b0, 4'b0000, 1'b1, rnd_addr(), rnd_data());
    checks++;
    if (clear_busy !== 1'b0) begin
      errors++; $display("FAIL noclr_busy: busy=%b want 0", clear_busy);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rf_wr !== 1'b0 || clear_busy !== 1'b0) begin
        errors++; $display("FAIL noclr[%0d]: wr=%b busy=%b want 0/0", c, rf_wr, clear_busy);
      end
      drive(1'b0, 4'b0000, 1'b0, rnd_addr(), rnd_data());
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] er;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 80) == 0, NREQ'($urandom), ($urandom % 60) == 0, rnd_addr(), rnd_data());
      er = m_ready();
      checks++;
      if (req_ready !== er || clear_busy !== (m_clear && !reset)) begin
        errors++; $display("FAIL rnd_ready[%0d]: ready=%b busy=%b want %b/%b", n, req_ready, clear_busy, er, m_clear && !reset);
      end
      tick();
      checks++;
      if (rf_wr !== e_wr || rf_enable !== e_en || rf_add_wr !== e_addr || rf_datain !== e_data) begin
        errors++; $display("FAIL rnd_out[%0d]: wr=%b en=%b addr=%0d data=%h want %b/%b/%0d/%h",
                           n, rf_wr, rf_enable, rf_add_wr, rf_datain, e_wr, e_en, e_addr, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_latency();
    test_same_addr();
`ifdef RFARB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
